// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a PS/2 device
// over the shared open-collector ps2_clk/ps2_data lines: request-to-send,
// data/parity/stop serialised on device falling clock edges, ack check.
//
// Ports:
//   clk, rst              system clock, async active-high reset
//   ps2_clk_i/ps2_data_i  raw line levels (synchronised here)
//   ps2_clk_oe/data_oe    1 = pull the line low, 0 = release
//   tx_valid/tx_data      command request; accepted when tx_ready is high
//   tx_ready              high only while idle
//   tx_active             high while a transfer is in flight (gates the receiver)
//   done                  one-cycle pulse at end of transfer
//   ack_ok, timeout       result of the transfer, held until the next accept
//
// Optional feature: define PS2_TX_RETRY_EN to retry a NACKed or timed-out
// transfer up to two more times before reporting done.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_active,
   output logic       done,
   output logic       ack_ok,
   output logic       timeout
);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAITIDLE, S_DONE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_s, data_s, clk_s_q, fe;
   logic [7:0]             data_q;
   logic                   parity_q;
   logic [3:0]             bit_cnt, bit_nxt;
   logic [IW-1:0]          inh_cnt;
   logic [TW-1:0]          to_cnt;
   logic                   timed, to_hit;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]             tries;
`endif

   // Lines idle high, so the synchronisers preset to 1 to avoid a false edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_s_q   <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
         clk_s_q   <= clk_s;
      end
   end

   assign clk_s   = clk_sync[SYNC_STAGES-1];
   assign data_s  = data_sync[SYNC_STAGES-1];
   assign fe      = clk_s_q & ~clk_s;
   assign bit_nxt = (bit_cnt == 4'd11) ? 4'd11 : bit_cnt + 4'd1;
   assign timed   = (state == S_REQ) || (state == S_SHIFT) ||
                    (state == S_ACK) || (state == S_WAITIDLE);
   assign to_hit  = timed && (to_cnt == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_ready    <= 1'b1;
         tx_active   <= 1'b0;
         done        <= 1'b0;
         ack_ok      <= 1'b0;
         timeout     <= 1'b0;
         data_q      <= '0;
         parity_q    <= 1'b0;
         bit_cnt     <= '0;
         inh_cnt     <= '0;
         to_cnt      <= '0;
`ifdef PS2_TX_RETRY_EN
         tries       <= '0;
`endif
      end else if (to_hit) begin
         // Timeout takes priority over any edge seen in the same cycle.
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         timeout     <= 1'b1;
         ack_ok      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         if (tries != 2'd2) begin
            tries      <= tries + 2'd1;
            state      <= S_INHIBIT;
            ps2_clk_oe <= 1'b1;
            inh_cnt    <= '0;
         end else
`endif
         begin
            state <= S_DONE;
            done  <= 1'b1;
         end
      end else begin
         if (timed) to_cnt <= to_cnt + TW'(1);
         case (state)
            S_IDLE: begin
               if (tx_valid) begin
                  data_q     <= tx_data;
                  parity_q   <= ~^tx_data;
                  state      <= S_INHIBIT;
                  ps2_clk_oe <= 1'b1;
                  inh_cnt    <= '0;
                  tx_ready   <= 1'b0;
                  tx_active  <= 1'b1;
                  ack_ok     <= 1'b0;
                  timeout    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                  tries      <= '0;
`endif
               end
            end
            // Edges here are our own clock pull-down and are ignored.
            S_INHIBIT: begin
               inh_cnt <= inh_cnt + IW'(1);
               if (inh_cnt == INH_PRE) ps2_data_oe <= 1'b1;
               if (inh_cnt == INH_LAST) begin
                  state      <= S_REQ;
                  ps2_clk_oe <= 1'b0;
                  to_cnt     <= '0;
               end
            end
            S_REQ: begin
               ps2_data_oe <= 1'b1;
               bit_cnt     <= '0;
               state       <= S_SHIFT;
            end
            S_SHIFT: begin
               if (fe) begin
                  bit_cnt <= bit_nxt;
                  if (bit_cnt < 4'd8) begin
                     ps2_data_oe <= ~data_q[bit_cnt[2:0]];
                  end else if (bit_cnt == 4'd8) begin
                     ps2_data_oe <= ~parity_q;
                  end else begin
                     ps2_data_oe <= 1'b0;
                     state       <= S_ACK;
                  end
               end
            end
            S_ACK: begin
               if (fe) begin
                  bit_cnt <= bit_nxt;
                  ack_ok  <= ~data_s;
                  state   <= S_WAITIDLE;
               end
            end
            S_WAITIDLE: begin
               if (clk_s && data_s) begin
`ifdef PS2_TX_RETRY_EN
                  if (!ack_ok && tries != 2'd2) begin
                     tries      <= tries + 2'd1;
                     state      <= S_INHIBIT;
                     ps2_clk_oe <= 1'b1;
                     inh_cnt    <= '0;
                  end else
`endif
                  begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               done      <= 1'b0;
               state     <= S_IDLE;
               tx_ready  <= 1'b1;
               tx_active <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
   localparam int INH = 10;
   localparam int TMO = 200;
   localparam int H   = 6;
`ifdef PS2_TX_RETRY_EN
   localparam int ATT = 3;
`else
   localparam int ATT = 1;
`endif

   logic clk = 1'b0, rst = 1'b0;
   logic dev_clk = 1'b1, dev_data = 1'b1;
   logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
   logic tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic tx_ready, tx_active, done, ack_ok, timeout;

   assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_i = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx_active(tx_active),
      .done(done), .ack_ok(ack_ok), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [10:0] exp_q[$];
   int dev_bit = 0;

   // Event monitor, sampled on the falling clock edge.
   int cyc = 0, done_cnt = 0, done_cyc = 0, req_cyc = 0, act_cyc = 0;
   int oe_run = 0, oe_len = 0, inh_phases = 0;
   logic prev_clk_oe = 1'b0, prev_act = 1'b0;
   logic last_ack = 1'b0, last_to = 1'b0;
   logic [1:0] done_oe = 2'b00;

   always @(negedge clk) begin
      cyc         <= cyc + 1;
      prev_clk_oe <= ps2_clk_oe;
      prev_act    <= tx_active;
      oe_run      <= ps2_clk_oe ? oe_run + 1 : 0;
      if (ps2_clk_oe && !prev_clk_oe) inh_phases <= inh_phases + 1;
      if (!ps2_clk_oe && prev_clk_oe) begin
         req_cyc <= cyc;
         oe_len  <= oe_run;
      end
      if (tx_active && !prev_act) act_cyc <= cyc;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         last_ack <= ack_ok;
         last_to  <= timeout;
         done_oe  <= {ps2_clk_oe, ps2_data_oe};
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic bound_fail(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: wait expired", tag);
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

   task automatic send(input logic [7:0] d, input bit push);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      if (push) exp_q.push_back(frame(d));
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int n0);
      int k = 0;
      while (done_cnt == n0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt == n0) bound_fail(tag);
   endtask

   // Device model: mode 0 = ack, 1 = nack. Captures the 11-bit frame
   // (start, 8 data LSB first, parity, stop) and scores it against the queue.
   task automatic dev_frame(input int mode, input bit chk);
      logic [10:0] fr;
      logic prev, got;
      int n;
      fr = '0; n = 0; got = 1'b0;
      prev = ps2_clk_oe;
      do begin
         @(negedge clk);
         n++;
         got  = prev && !ps2_clk_oe;
         prev = ps2_clk_oe;
      end while (!got && n < 3000);
      if (!got) begin
         bound_fail("dev_req");
         return;
      end
      fr[0] = ps2_data_i;
      repeat (4) @(negedge clk);
      for (int i = 1; i <= 11; i++) begin
         dev_bit = i;
         if (i == 11) dev_data = (mode == 0) ? 1'b0 : 1'b1;
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         if (i <= 10) fr[i] = ps2_data_i;
         dev_clk = 1'b1;
         repeat (H) @(negedge clk);
      end
      dev_data = 1'b1;
      if (chk) begin
         if (exp_q.size() == 0) bound_fail("frame_queue_empty");
         else check("frame", 32'(fr), 32'(exp_q.pop_front()));
      end
   endtask

   initial begin
      int n0, i0, d1, k;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_done", done, 0);
      check("rst_ack", ack_ok, 0);
      check("rst_timeout", timeout, 0);
      check("rst_ready", tx_ready, 1);
      check("rst_active", tx_active, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 0xED, acked
      n0 = done_cnt;
      fork
         send(8'hED, 1);
         dev_frame(0, 1);
      join
      wait_done("ed_done", n0);
      check("ed_inhibit_len", oe_len, INH);
      check("ed_ack", last_ack, 1);
      check("ed_timeout", last_to, 0);
      check("ed_ack_hold", ack_ok, 1);

      // 0x01 with a stray tx_valid pulse mid-transfer
      n0 = done_cnt;
      fork
         send(8'h01, 1);
         dev_frame(0, 1);
         begin
            repeat (60) @(negedge clk);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
         end
      join
      wait_done("x01_done", n0);
      check("x01_ack", last_ack, 1);
      repeat (20) @(negedge clk);
      check("ignore_one_done", done_cnt, n0 + 1);
      check("ignore_idle", tx_active, 0);

      // 0x00
      n0 = done_cnt;
      fork
         send(8'h00, 1);
         dev_frame(0, 1);
      join
      wait_done("x00_done", n0);
      check("x00_ack", last_ack, 1);

      // NACK
      n0 = done_cnt;
      i0 = inh_phases;
      for (int a = 1; a < ATT; a++) exp_q.push_back(frame(8'hA5));
      fork
         send(8'hA5, 1);
         for (int a = 0; a < ATT; a++) dev_frame(1, 1);
      join
      wait_done("nack_done", n0);
      check("nack_ack", last_ack, 0);
      check("nack_timeout", last_to, 0);
      check("nack_attempts", inh_phases - i0, ATT);
      check("nack_one_done", done_cnt, n0 + 1);

      // Silent device -> timeout
      n0 = done_cnt;
      send(8'h3C, 0);
      wait_done("to_done", n0);
      check("to_latency", done_cyc - req_cyc, TMO);
      check("to_flag", last_to, 1);
      check("to_ack", last_ack, 0);
      check("to_lines", done_oe, 0);

      // Reset during SHIFT
      n0 = done_cnt;
      dev_bit = 0;
      fork
         send(8'h50, 0);
         dev_frame(0, 0);
         begin
            k = 0;
            while (dev_bit != 4 && k < 3000) begin
               @(negedge clk);
               k++;
            end
            if (dev_bit != 4) bound_fail("rst_wait_bit4");
            repeat (H) @(negedge clk);
            check("pre_rst_data_oe", ps2_data_oe, 1);
            #2 rst = 1'b1;
            #1;
            check("mid_rst_clk_oe", ps2_clk_oe, 0);
            check("mid_rst_data_oe", ps2_data_oe, 0);
            check("mid_rst_ready", tx_ready, 1);
            check("mid_rst_active", tx_active, 0);
            @(negedge clk);
            rst = 1'b0;
         end
      join
      repeat (10) @(negedge clk);
      check("rst_no_done", done_cnt, n0);
      check("rst_idle_ready", tx_ready, 1);

      // Back-to-back with tx_valid held
      n0 = done_cnt;
      d1 = 0;
      fork
         begin
            @(negedge clk);
            tx_data  = 8'hFF;
            tx_valid = 1'b1;
            exp_q.push_back(frame(8'hFF));
            @(negedge clk);
            tx_data = 8'hF4;
            exp_q.push_back(frame(8'hF4));
            wait_done("b2b_first", n0);
            d1 = done_cyc;
            k = 0;
            while (!tx_active && k < 100) begin
               @(negedge clk);
               k++;
            end
            if (!tx_active) bound_fail("b2b_second_accept");
            tx_valid = 1'b0;
            wait_done("b2b_second", n0 + 1);
         end
         begin
            dev_frame(0, 1);
            dev_frame(0, 1);
         end
      join
      check("b2b_gap", act_cyc - d1, 2);
      check("b2b_ack", last_ack, 1);
      check("b2b_queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
